// File: rtl/cc_matrix_serial_tx.sv
// Parallel-to-serial transmitter for a MAX7219-style 3-wire link (SCLK/SDATA/LOAD).
// Sends one DATAWIDTH word MSB-first per accepted active-low start request.
module cc_matrix_serial_tx #(
  parameter int unsigned CC_SERIALTX_DATAWIDTH = 16,
  parameter int unsigned CC_SERIALTX_CLKDIV    = 4
) (
  input  logic                             CC_SERIALTX_CLOCK_50,
  input  logic                             CC_SERIALTX_RESET_InHigh,
  input  logic [CC_SERIALTX_DATAWIDTH-1:0] CC_SERIALTX_data_InBUS,
  input  logic                             CC_SERIALTX_start_InLow,
  output logic                             CC_SERIALTX_ready_Out,
  output logic                             CC_SERIALTX_done_Out,
  output logic                             CC_SERIALTX_sclk_Out,
  output logic                             CC_SERIALTX_sdata_Out,
  output logic                             CC_SERIALTX_load_Out
);

  localparam int unsigned DW    = CC_SERIALTX_DATAWIDTH;
  localparam int unsigned CD    = CC_SERIALTX_CLKDIV;
  localparam int unsigned DIV_W = $clog2(CD + 1);
  localparam int unsigned BIT_W = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_LOW  = 2'd1,
    SHIFT_HIGH = 2'd2,
    LATCH      = 2'd3
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic [DW-1:0]    shift_q;
  logic             ready_q;
  logic             done_q;
  logic             sclk_q;
  logic             sdata_q;
  logic             load_q;

  logic div_end;
  assign div_end = (div_q == DIV_W'(CD - 1));

  // Frame sequencer; every output is a register updated alongside the state.
  always_ff @(posedge CC_SERIALTX_CLOCK_50 or posedge CC_SERIALTX_RESET_InHigh) begin
    if (CC_SERIALTX_RESET_InHigh) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          load_q  <= 1'b1;
          sclk_q  <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
          if (!CC_SERIALTX_start_InLow) begin
            shift_q <= CC_SERIALTX_data_InBUS;
            sdata_q <= CC_SERIALTX_data_InBUS[DW-1];
            load_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= SHIFT_LOW;
          end
        end
        SHIFT_LOW: begin
          ready_q <= 1'b0;
          if (div_end) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT_HIGH;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        SHIFT_HIGH: begin
          if (div_end) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            shift_q <= shift_q << 1;
            bit_q   <= bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DW - 1)) begin
              load_q  <= 1'b1;
              sdata_q <= 1'b0;
              state_q <= LATCH;
            end else begin
              // Next bit appears only on SHIFT_LOW entry for full setup before the rise.
              sdata_q <= shift_q[DW-2];
              state_q <= SHIFT_LOW;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_end) begin
            div_q   <= '0;
            bit_q   <= '0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            // A held start chains the next frame straight out of the latch window.
            if (!CC_SERIALTX_start_InLow) begin
              shift_q <= CC_SERIALTX_data_InBUS;
              sdata_q <= CC_SERIALTX_data_InBUS[DW-1];
              load_q  <= 1'b0;
              state_q <= SHIFT_LOW;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CC_SERIALTX_ready_Out = ready_q;
  assign CC_SERIALTX_done_Out  = done_q;
  assign CC_SERIALTX_sclk_Out  = sclk_q;
  assign CC_SERIALTX_sdata_Out = sdata_q;
  assign CC_SERIALTX_load_Out  = load_q;

endmodule
